mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter Depth, default 4, max outstanding accepted requests; power of two, >= 2.
REQ-002 SHALL have ports clk_i in 1 clock; rst_ni in 1 asynchronous active-low reset.
REQ-003 SHALL have ports inst_valid_i in 1, inst_ready_o out 1, inst_addr_i in Xlen, inst_wdata_i in Xlen, inst_wmask_i in MaskBits, inst_rdata_o out Xlen, inst_rvalid_o out 1: the instruction requester.
REQ-004 SHALL have ports data_valid_i, data_ready_o, data_addr_i, data_wdata_i, data_wmask_i, data_rdata_o, data_rvalid_o with the same widths: the data requester.
REQ-005 SHALL have ports mem_valid_o out 1, mem_ready_i in 1, mem_addr_o out Xlen, mem_wdata_o out Xlen, mem_wmask_o out MaskBits, mem_rdata_i in Xlen, mem_rvalid_i in 1: the shared memory port.
REQ-006 SHALL have port err_o out 1: sticky, set on an unexpected response.

Function
REQ-007 A request SHALL be accepted on a cycle with valid and ready both high, on either port.
REQ-008 The grant SHALL go to at most one requester per cycle; mem_addr_o/wdata_o/wmask_o SHALL mux from the granted requester.
REQ-009 mem_valid_o SHALL equal (inst_valid_i or data_valid_i) and not full; its value is don't-care-free (0) when no grant.
REQ-010 The granted requester's ready_o SHALL equal mem_ready_i and not full; the other requester's ready_o SHALL be 0.
REQ-011 Every accepted request, load or store (wmask nonzero), SHALL produce exactly one mem_rvalid_i, in order, no earlier than the cycle after acceptance.
REQ-012 On acceptance, the requester ID (ReqInst/ReqData) SHALL be pushed into an ID FIFO of Depth entries.
REQ-013 On mem_rvalid_i with FIFO non-empty, the head ID SHALL be popped, and mem_rdata_i SHALL be routed combinationally to that requester's rdata_o with its rvalid_o high for that cycle only.
REQ-014 inst_rdata_o and data_rdata_o SHALL both carry mem_rdata_i; only rvalid is steered.
REQ-015 full SHALL be count == Depth; no grant while full, even if a response pops that same cycle.
REQ-016 Simultaneous push and pop SHALL leave count unchanged; the write and read pointers SHALL wrap modulo Depth.
REQ-017 mem_rvalid_i with FIFO empty SHALL be dropped (no rvalid_o), SHALL set err_o, and err_o SHALL hold until reset.
REQ-018 No output SHALL depend combinationally on mem_rvalid_i except the rvalid_o and rdata_o outputs.

Reset
REQ-019 Assertion of rst_ni SHALL asynchronously clear count, pointers, err_o and the round-robin pointer (pointing to data).
REQ-020 During and immediately after reset, mem_valid_o, both ready_o and both rvalid_o SHALL be 0 absent requests.
REQ-021 Reset mid-transaction SHALL discard all outstanding IDs; a later response SHALL be treated per REQ-017.

Configuration
REQ-022 Macro MEM_ARBITER_RR_EN, when defined, SHALL select round-robin arbitration: on contention, grant the requester not granted last; the last-grant pointer updates only on acceptance.
REQ-023 Without MEM_ARBITER_RR_EN, data SHALL have fixed priority over inst, and no pointer register SHALL exist.

Structure
REQ-024 Enum req_id_e {ReqInst, ReqData} SHALL reside in core_pkg, alongside the existing Xlen and MaskBits.
REQ-025 The ID FIFO SHALL be a sub-module arb_id_fifo (parameters Depth and the element type width), with push, pop, full, empty and head outputs.

Verification
REQ-026 Inst req addr 0x100, no data, mem_ready_i=1; rvalid next cycle with rdata 0x13 -> inst_rvalid_o=1, inst_rdata_o=0x13, data_rvalid_o=0.
REQ-027 Both valid, same cycle -> without macro, data granted each cycle until data_valid_i drops; with macro, grants alternate D,I,D,I over 4 cycles.
REQ-028 4 accepted, no responses -> 5th stalled (ready 0, mem_valid_o 0); one rvalid -> the following cycle accepts.
REQ-029 Accept I,D,I, then responses 0xA,0xB,0xC -> inst gets 0xA, data gets 0xB, inst gets 0xC, in order.
REQ-030 mem_rvalid_i with nothing outstanding -> no rvalid_o, err_o=1 and sticky; rst_ni low -> err_o=0.
REQ-031 mem_ready_i=0 for 3 cycles with data valid -> no push, address held stable, accepted on the first ready cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and widths for the memory-side blocks.
package core_pkg;

    localparam int Xlen     = 32;
    localparam int MaskBits = Xlen / 8;

    // Identifies which requester owns an outstanding memory transaction.
    typedef enum logic {
        ReqInst = 1'b0,
        ReqData = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_id_fifo.sv
// Circular FIFO holding the requester ID of every outstanding memory request.
// Depth must be a power of two so the pointers wrap naturally.
module arb_id_fifo #(
    parameter int Depth = 4,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: the storage array is deliberately left without reset; validity is
    // tracked by count_q alone, and a reset-free array maps onto plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one in-order memory port.
// Define MEM_ARBITER_RR_EN for round-robin; otherwise data has fixed priority.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                inst_valid_i,
    output logic                inst_ready_o,
    input  logic [Xlen-1:0]     inst_addr_i,
    input  logic [Xlen-1:0]     inst_wdata_i,
    input  logic [MaskBits-1:0] inst_wmask_i,
    output logic [Xlen-1:0]     inst_rdata_o,
    output logic                inst_rvalid_o,

    input  logic                data_valid_i,
    output logic                data_ready_o,
    input  logic [Xlen-1:0]     data_addr_i,
    input  logic [Xlen-1:0]     data_wdata_i,
    input  logic [MaskBits-1:0] data_wmask_i,
    output logic [Xlen-1:0]     data_rdata_o,
    output logic                data_rvalid_o,

    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i,

    output logic                err_o
);

    localparam int IdW = $bits(req_id_e);

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           prefer_data;
    logic           grant_inst;
    logic           grant_data;
    logic [IdW-1:0] push_id;
    logic [IdW-1:0] head;
    req_id_e        head_id;
    logic           err_q;

`ifdef MEM_ARBITER_RR_EN
    // Points at the requester that wins the next contended cycle.
    req_id_e prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= ReqData;
        end else if (push) begin
            prio_q <= grant_data ? ReqInst : ReqData;
        end
    end

    assign prefer_data = (prio_q == ReqData);
`else
    assign prefer_data = 1'b1;
`endif

    // Grants depend only on registered occupancy, never on the response path.
    assign grant_data = !full && data_valid_i && (!inst_valid_i || prefer_data);
    assign grant_inst = !full && inst_valid_i && (!data_valid_i || !prefer_data);

    assign mem_valid_o  = grant_inst || grant_data;
    assign inst_ready_o = grant_inst && mem_ready_i;
    assign data_ready_o = grant_data && mem_ready_i;
    assign push         = mem_valid_o && mem_ready_i;
    assign push_id      = grant_data ? IdW'(ReqData) : IdW'(ReqInst);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (grant_data) begin
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
            mem_wmask_o = data_wmask_i;
        end else if (grant_inst) begin
            mem_addr_o  = inst_addr_i;
            mem_wdata_o = inst_wdata_i;
            mem_wmask_o = inst_wmask_i;
        end
    end

    arb_id_fifo #(
        .Depth (Depth),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_id),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign head_id       = req_id_e'(head);
    assign pop           = mem_rvalid_i && !empty;
    assign inst_rvalid_o = pop && (head_id == ReqInst);
    assign data_rvalid_o = pop && (head_id == ReqData);
    assign inst_rdata_o  = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    // A response with nothing outstanding is dropped and flagged until reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (mem_rvalid_i && empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based model of outstanding requests.
module tb_mem_arbiter;
    import core_pkg::*;

    localparam int DEPTH = 4;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                iv = 1'b0, dv = 1'b0, mr = 1'b0, rv = 1'b0;
    logic [Xlen-1:0]     ia = '0, iwd = '0, da = '0, dwd = '0, rd = '0;
    logic [MaskBits-1:0] iwm = '0, dwm = '0;
    logic                inst_ready, data_ready, inst_rvalid, data_rvalid;
    logic                mem_valid, err;
    logic [Xlen-1:0]     inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [MaskBits-1:0] mem_wmask;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of outstanding owners (0 = inst, 1 = data).
    int id_q[$];
    bit err_m = 1'b0;
    bit pref_data = 1'b1;

    // Values sampled during the most recent cycle() for directed checks.
    logic s_mvalid, s_iready, s_dready, s_irvalid, s_drvalid, s_err;
    logic [Xlen-1:0] s_addr, s_irdata;

    always #5 clk = ~clk;

    mem_arbiter #(.Depth(DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .inst_valid_i  (iv),
        .inst_ready_o  (inst_ready),
        .inst_addr_i   (ia),
        .inst_wdata_i  (iwd),
        .inst_wmask_i  (iwm),
        .inst_rdata_o  (inst_rdata),
        .inst_rvalid_o (inst_rvalid),
        .data_valid_i  (dv),
        .data_ready_o  (data_ready),
        .data_addr_i   (da),
        .data_wdata_i  (dwd),
        .data_wmask_i  (dwm),
        .data_rdata_o  (data_rdata),
        .data_rvalid_o (data_rvalid),
        .mem_valid_o   (mem_valid),
        .mem_ready_i   (mr),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_wmask_o   (mem_wmask),
        .mem_rdata_i   (rd),
        .mem_rvalid_i  (rv),
        .err_o         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare every output against the model at mid-cycle, then advance.
    task automatic cycle(input string tag);
        bit full, gi, gd, exp_valid, has_resp;
        int head;
        logic [Xlen-1:0] exp_addr, exp_wdata;
        logic [MaskBits-1:0] exp_wmask;
        @(negedge clk);
        full = (id_q.size() == DEPTH);
        gi = 1'b0;
        gd = 1'b0;
        if (!full) begin
            if (iv && dv) begin
                if (!RR_EN || pref_data) gd = 1'b1;
                else gi = 1'b1;
            end else begin
                gi = iv;
                gd = dv;
            end
        end
        exp_valid = gi || gd;
        exp_addr  = gd ? da  : (gi ? ia  : '0);
        exp_wdata = gd ? dwd : (gi ? iwd : '0);
        exp_wmask = gd ? dwm : (gi ? iwm : '0);
        has_resp  = rv && (id_q.size() > 0);
        head      = (id_q.size() > 0) ? id_q[0] : -1;

        check({tag, ".mem_valid"}, 32'(mem_valid), 32'(exp_valid));
        check({tag, ".inst_ready"}, 32'(inst_ready), 32'(gi && mr));
        check({tag, ".data_ready"}, 32'(data_ready), 32'(gd && mr));
        check({tag, ".mem_addr"}, mem_addr, exp_addr);
        check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, ".mem_wmask"}, 32'(mem_wmask), 32'(exp_wmask));
        check({tag, ".inst_rvalid"}, 32'(inst_rvalid), 32'(has_resp && head == 0));
        check({tag, ".data_rvalid"}, 32'(data_rvalid), 32'(has_resp && head == 1));
        check({tag, ".inst_rdata"}, inst_rdata, rd);
        check({tag, ".data_rdata"}, data_rdata, rd);
        check({tag, ".err"}, 32'(err), 32'(err_m));

        s_mvalid = mem_valid;   s_iready = inst_ready; s_dready = data_ready;
        s_irvalid = inst_rvalid; s_drvalid = data_rvalid; s_err = err;
        s_addr = mem_addr;      s_irdata = inst_rdata;

        if (rv && id_q.size() == 0) err_m = 1'b1;
        if (has_resp) void'(id_q.pop_front());
        if (exp_valid && mr) begin
            id_q.push_back(gd ? 1 : 0);
            pref_data = gi;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iv = 1'b0; dv = 1'b0; mr = 1'b0; rv = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst.mem_valid", 32'(mem_valid), 32'd0);
        check("rst.inst_ready", 32'(inst_ready), 32'd0);
        check("rst.data_ready", 32'(data_ready), 32'd0);
        check("rst.inst_rvalid", 32'(inst_rvalid), 32'd0);
        check("rst.data_rvalid", 32'(data_rvalid), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        id_q.delete();
        err_m = 1'b0;
        pref_data = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        cycle("post_reset");

        // Single instruction fetch and its response.
        iv = 1'b1; ia = 32'h100; iwm = '0; mr = 1'b1;
        cycle("r26_req");
        check("r26_accept", 32'(s_iready), 32'd1);
        iv = 1'b0; rv = 1'b1; rd = 32'h13;
        cycle("r26_resp");
        check("r26_irvalid", 32'(s_irvalid), 32'd1);
        check("r26_irdata", s_irdata, 32'h13);
        check("r26_drvalid", 32'(s_drvalid), 32'd0);
        rv = 1'b0;

        // Contention for four cycles.
        iv = 1'b1; dv = 1'b1; ia = 32'h40; da = 32'h80; mr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle("r27_contend");
            check("r27_dready", 32'(s_dready), RR_EN ? 32'(k % 2 == 0) : 32'd1);
        end
        // Queue is now full: fifth request stalls, even on the popping cycle.
        iv = 1'b0;
        cycle("r28_full");
        check("r28_stall_ready", 32'(s_dready), 32'd0);
        check("r28_stall_valid", 32'(s_mvalid), 32'd0);
        rv = 1'b1; rd = 32'h55;
        cycle("r28_pop");
        check("r28_pop_stall", 32'(s_dready), 32'd0);
        rv = 1'b0;
        cycle("r28_accept");
        check("r28_accept", 32'(s_dready), 32'd1);
        dv = 1'b0;
        rv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rd = 32'h200 + 32'(k);
            cycle("r28_drain");
        end
        rv = 1'b0;

        // In-order routing of I, D, I.
        iv = 1'b1; ia = 32'h10; cycle("r29_i0");
        iv = 1'b0; dv = 1'b1; da = 32'h20; dwm = 4'hF; dwd = 32'hCAFE; cycle("r29_d");
        dv = 1'b0; dwm = '0; iv = 1'b1; ia = 32'h30; cycle("r29_i1");
        iv = 1'b0; rv = 1'b1;
        rd = 32'hA; cycle("r29_ra");
        check("r29_a_inst", 32'(s_irvalid), 32'd1);
        rd = 32'hB; cycle("r29_rb");
        check("r29_b_data", 32'(s_drvalid), 32'd1);
        rd = 32'hC; cycle("r29_rc");
        check("r29_c_inst", 32'(s_irvalid), 32'd1);

        // Stray response raises a sticky error; reset clears it.
        cycle("r30_stray");
        check("r30_no_irvalid", 32'(s_irvalid), 32'd0);
        check("r30_no_drvalid", 32'(s_drvalid), 32'd0);
        rv = 1'b0;
        cycle("r30_err");
        check("r30_err_set", 32'(s_err), 32'd1);
        cycle("r30_sticky");
        check("r30_err_sticky", 32'(s_err), 32'd1);
        do_reset();

        // Reset mid-transaction discards the outstanding ID.
        iv = 1'b1; mr = 1'b1; ia = 32'h44; cycle("r21_req");
        do_reset();
        rv = 1'b1; rd = 32'h77; cycle("r21_resp");
        check("r21_dropped", 32'(s_irvalid), 32'd0);
        rv = 1'b0; cycle("r21_err");
        check("r21_err", 32'(s_err), 32'd1);
        do_reset();

        // Memory back-pressure holds the request.
        dv = 1'b1; da = 32'h200; mr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("r31_wait");
            check("r31_addr_held", s_addr, 32'h200);
            check("r31_not_ready", 32'(s_dready), 32'd0);
        end
        mr = 1'b1; cycle("r31_go");
        check("r31_accept", 32'(s_dready), 32'd1);
        dv = 1'b0; rv = 1'b1; cycle("r31_resp");
        check("r31_drvalid", 32'(s_drvalid), 32'd1);
        rv = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            iv  = 1'($urandom_range(0, 1));
            dv  = 1'($urandom_range(0, 1));
            ia  = $urandom(); da = $urandom();
            iwd = $urandom(); dwd = $urandom();
            iwm = 4'($urandom()); dwm = 4'($urandom());
            mr  = ($urandom_range(0, 3) != 0);
            rd  = $urandom();
            rv  = (id_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
            cycle("rand");
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
